// File: rtl/crg_pkg.sv
// Shared clock/reset-generation types and default cycle constants.
package crg_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } rst_seq_state_e;

    localparam int unsigned DRAM_HOLD_CYCLES_100M = 65000;
    localparam int unsigned RESTART_CNT_W         = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_release_sequencer_if.sv
// Lock/request inputs and sequenced reset outputs of the reset release sequencer.
interface reset_release_sequencer_if #(
    parameter int unsigned NUM_DOMAINS = 3
);
    import crg_pkg::*;

    logic                     pll_locked;
    logic                     sw_reset_req;
    logic [NUM_DOMAINS-1:0]   domain_rst;
    logic                     ready;
    logic [RESTART_CNT_W-1:0] restart_count;

    modport master (
        output pll_locked,
        output sw_reset_req,
        input  domain_rst,
        input  ready,
        input  restart_count
    );

    modport slave (
        input  pll_locked,
        input  sw_reset_req,
        output domain_rst,
        output ready,
        output restart_count
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/reset_release_sequencer.sv
// Holds domain resets until PLL lock is stable, waits a hold time, then releases the
// domains one at a time in index order; restarts on lock loss or software request.
module reset_release_sequencer
    import crg_pkg::*;
#(
    parameter int unsigned  NUM_DOMAINS        = 3,
    parameter int unsigned  HOLD_CYCLES        = DRAM_HOLD_CYCLES_100M,
    parameter int unsigned  STAGE_GAP_CYCLES   = 16,
    parameter int unsigned  LOCK_FILTER_CYCLES = 8,
    localparam int unsigned CNT_WIDTH          =
        $clog2(max3(HOLD_CYCLES, STAGE_GAP_CYCLES, LOCK_FILTER_CYCLES) + 1)
) (
    input logic                clk,
    input logic                rst,
    reset_release_sequencer_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    if (STAGE_GAP_CYCLES == 0) begin : g_bad_gap
        $error("STAGE_GAP_CYCLES must be at least 1");
    end
    if (LOCK_FILTER_CYCLES == 0) begin : g_bad_filter
        $error("LOCK_FILTER_CYCLES must be at least 1");
    end
    if (NUM_DOMAINS == 0) begin : g_bad_domains
        $error("NUM_DOMAINS must be at least 1");
    end

    rst_seq_state_e           r_state;
    logic [CNT_WIDTH-1:0]     r_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic [NUM_DOMAINS-1:0]   r_domain_rst;
    logic                     r_ready;
    logic [RESTART_CNT_W-1:0] r_restart_count;

    logic w_lock_s;
    logic w_abort;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.pll_locked),
        .o_q (w_lock_s)
    );

    // Lock loss only aborts once the filter has accepted lock; in WAIT_LOCK it just refilters.
    assign w_abort = bus.sw_reset_req | (~w_lock_s & (r_state != WAIT_LOCK));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= WAIT_LOCK;
            r_cnt           <= '0;
            r_idx           <= '0;
            r_domain_rst    <= '1;
            r_ready         <= 1'b0;
            r_restart_count <= '0;
        end else if (w_abort) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_domain_rst <= '1;
            r_ready      <= 1'b0;
            if (r_restart_count != '1) begin
                r_restart_count <= r_restart_count + RESTART_CNT_W'(1);
            end
        end else begin
            unique case (r_state)
                WAIT_LOCK: begin
                    if (!w_lock_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_WIDTH'(LOCK_FILTER_CYCLES)) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (r_cnt == CNT_WIDTH'(HOLD_CYCLES - 1)) begin
                        r_cnt           <= '0;
                        r_domain_rst[0] <= 1'b0;
                        if (NUM_DOMAINS == 1) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= RELEASE;
                            r_idx   <= IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                RELEASE: begin
                    if (r_cnt == CNT_WIDTH'(STAGE_GAP_CYCLES - 1)) begin
                        r_cnt               <= '0;
                        r_domain_rst[r_idx] <= 1'b0;
                        if (r_idx == IDX_W'(NUM_DOMAINS - 1)) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign bus.domain_rst    = r_domain_rst;
    assign bus.ready         = r_ready;
    assign bus.restart_count = r_restart_count;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer: timed expectations queued ahead of the
// stimulus and compared on the edge they fall due, plus per-cycle ordering checks.
module tb_reset_release_sequencer;
    import crg_pkg::*;

    localparam int unsigned N = 3;
    localparam int unsigned H = 100;
    localparam int unsigned G = 4;
    localparam int unsigned F = 3;

    typedef struct {
        int unsigned edge_n;
        logic [2:0]  dom;
        logic        rdy;
        logic [7:0]  rc;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          inv_en = 1'b0;
    logic [2:0]  prev_dom = 3'b111;

    always #5 clk = ~clk;

    reset_release_sequencer_if #(.NUM_DOMAINS(N)) bus ();

    reset_release_sequencer #(
        .NUM_DOMAINS        (N),
        .HOLD_CYCLES        (H),
        .STAGE_GAP_CYCLES   (G),
        .LOCK_FILTER_CYCLES (F)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic ordered_ok(input logic [2:0] d);
        logic [2:0] z;
        z = ~d;
        return ((z & (z + 3'd1)) == 3'd0);
    endfunction

    function automatic logic single_release(input logic [2:0] p, input logic [2:0] d);
        logic [2:0] f;
        f = p & ~d;
        return ((f & (f - 3'd1)) == 3'd0);
    endfunction

    task automatic expect_at(input int unsigned e, input logic [2:0] d, input logic r,
                             input logic [7:0] c, input string t);
        exp_t x;
        x.edge_n = e;
        x.dom    = d;
        x.rdy    = r;
        x.rc     = c;
        x.tag    = t;
        sb.push_back(x);
    endtask

    task automatic check_due();
        while (sb.size() > 0 && sb[0].edge_n <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            checks++;
            assert (x.edge_n == cyc &&
                    {bus.domain_rst, bus.ready, bus.restart_count} === {x.dom, x.rdy, x.rc})
            else begin
                errors++;
                $error("FAIL %s edge %0d (at %0d): got dom=%b ready=%b rc=%0d, want dom=%b ready=%b rc=%0d",
                       x.tag, x.edge_n, cyc, bus.domain_rst, bus.ready, bus.restart_count,
                       x.dom, x.rdy, x.rc);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_due();
    endtask

    always @(negedge clk) begin
        if (inv_en) begin
            checks++;
            assert (ordered_ok(bus.domain_rst) === 1'b1)
            else begin
                errors++;
                $error("FAIL order: got dom=%b, required released domains to be a low-index prefix",
                       bus.domain_rst);
            end
            checks++;
            assert (single_release(prev_dom, bus.domain_rst) === 1'b1)
            else begin
                errors++;
                $error("FAIL single_release: got dom=%b after %b, required at most one release per edge",
                       bus.domain_rst, prev_dom);
            end
        end
        prev_dom <= bus.domain_rst;
    end

    initial begin
        int unsigned base;
        int unsigned e0;
        int unsigned f0;
        int unsigned g0;
        int unsigned p0;
        int unsigned erc;
        logic [5:0]  seq;

        // Reset values, then straight lock from release.
        rst              = 1'b1;
        bus.pll_locked   = 1'b0;
        bus.sw_reset_req = 1'b0;
        tick();
        inv_en = 1'b1;
        repeat (3) tick();
        expect_at(cyc + 1, 3'b111, 1'b0, 8'd0, "rst_values");
        tick();
        rst            = 1'b0;
        bus.pll_locked = 1'b1;
        base           = cyc + 1;
        expect_at(base + 104, 3'b111, 1'b0, 8'd0, "s1_pre_rel0");
        expect_at(base + 105, 3'b110, 1'b0, 8'd0, "s1_rel0");
        expect_at(base + 108, 3'b110, 1'b0, 8'd0, "s1_pre_rel1");
        expect_at(base + 109, 3'b100, 1'b0, 8'd0, "s1_rel1");
        expect_at(base + 112, 3'b100, 1'b0, 8'd0, "s1_pre_rel2");
        expect_at(base + 113, 3'b000, 1'b1, 8'd0, "s1_ready");
        while (cyc < base + 120) tick();

        // Reset from RUN, then a glitchy lock that restarts the filter.
        expect_at(cyc + 1, 3'b111, 1'b0, 8'd0, "rst_in_run");
        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        tick();
        tick();
        rst  = 1'b0;
        base = cyc + 1;
        seq  = 6'b111011;
        expect_at(base + 7,   3'b111, 1'b0, 8'd0, "s2_filter");
        expect_at(base + 107, 3'b111, 1'b0, 8'd0, "s2_pre_rel0");
        expect_at(base + 108, 3'b110, 1'b0, 8'd0, "s2_rel0");
        expect_at(base + 112, 3'b100, 1'b0, 8'd0, "s2_rel1");
        expect_at(base + 116, 3'b000, 1'b1, 8'd0, "s2_ready");
        for (int k = 0; k < 6; k++) begin
            bus.pll_locked = seq[k];
            tick();
        end
        bus.pll_locked = 1'b1;
        while (cyc < base + 120) tick();

        // One-cycle lock drop in RUN, then relock.
        e0 = cyc;
        expect_at(e0 + 2,   3'b000, 1'b1, 8'd0, "s3_pre_abort");
        expect_at(e0 + 3,   3'b111, 1'b0, 8'd1, "s3_abort");
        expect_at(e0 + 106, 3'b111, 1'b0, 8'd1, "s3_pre_rel0");
        expect_at(e0 + 107, 3'b110, 1'b0, 8'd1, "s3_rel0");
        expect_at(e0 + 111, 3'b100, 1'b0, 8'd1, "s3_rel1");
        expect_at(e0 + 114, 3'b100, 1'b0, 8'd1, "s3_pre_rel2");
        expect_at(e0 + 115, 3'b000, 1'b1, 8'd1, "s3_ready");
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        while (cyc < e0 + 120) tick();

        // Software restart from RUN, then again mid-RELEASE.
        f0 = cyc;
        expect_at(f0 + 1,   3'b111, 1'b0, 8'd2, "s4_sw_run");
        expect_at(f0 + 105, 3'b110, 1'b0, 8'd2, "s4_rel0");
        expect_at(f0 + 106, 3'b111, 1'b0, 8'd3, "s4_sw_release");
        expect_at(f0 + 107, 3'b111, 1'b0, 8'd3, "s4_after_sw");
        bus.sw_reset_req = 1'b1;
        tick();
        bus.sw_reset_req = 1'b0;
        while (cyc < f0 + 105) tick();
        bus.sw_reset_req = 1'b1;
        tick();
        bus.sw_reset_req = 1'b0;

        // Lock loss and software request land on the same edge.
        g0 = cyc;
        expect_at(g0 + 104, 3'b110, 1'b0, 8'd3, "s4b_rel0");
        expect_at(g0 + 105, 3'b110, 1'b0, 8'd3, "s4b_hold_rel");
        expect_at(g0 + 106, 3'b111, 1'b0, 8'd4, "s4b_simul");
        expect_at(g0 + 107, 3'b111, 1'b0, 8'd4, "s4b_single_inc");
        while (cyc < g0 + 103) tick();
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        tick();
        bus.sw_reset_req = 1'b1;
        tick();
        bus.sw_reset_req = 1'b0;
        tick();

        // Saturating restart counter.
        for (int p = 1; p <= 260; p++) begin
            erc = 4 + p;
            if (erc > 255) erc = 255;
            expect_at(cyc + 1, 3'b111, 1'b0, 8'(erc), "s5_sat");
            bus.sw_reset_req = 1'b1;
            tick();
            bus.sw_reset_req = 1'b0;
            tick();
        end

        // Reset during HOLD with lock held high; sync flops must restart too.
        p0 = cyc - 1;
        while (cyc < p0 + 49) tick();
        expect_at(p0 + 50, 3'b111, 1'b0, 8'd0, "s6_rst_hold");
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        base = cyc + 1;
        expect_at(base + 104, 3'b111, 1'b0, 8'd0, "s6_pre_rel0");
        expect_at(base + 105, 3'b110, 1'b0, 8'd0, "s6_rel0");
        expect_at(base + 113, 3'b000, 1'b1, 8'd0, "s6_ready");
        while (cyc < base + 118) tick();
        expect_at(cyc + 1, 3'b111, 1'b0, 8'd0, "s6_rst_run");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
